// File: rtl/filter_ctrl.sv
// Control sequencer for the myfilter FIR datapath: sample write, accumulator clear, tap MAC loop, result handshake.
// Optional FILTER_CNT_EN adds a 16-bit count of completed output handshakes (port sample_cnt).
module filter_ctrl #(
  parameter int FILTER_TAPS = 8,
  parameter int ADDRBITS    = $clog2(FILTER_TAPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                sample_we,
  output logic [ADDRBITS-1:0] coeff_addr,
  output logic [ADDRBITS-1:0] data_addr,
  output logic [1:0]          acc_cmd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
`ifdef FILTER_CNT_EN
  ,
  output logic [15:0]         sample_cnt
`endif
);

  localparam logic [1:0] ACC_NOP   = 2'b00;
  localparam logic [1:0] ACC_CLEAR = 2'b01;
  localparam logic [1:0] ACC_LOAD  = 2'b10;

  localparam logic [ADDRBITS-1:0] LAST_IDX = ADDRBITS'(FILTER_TAPS - 1);
  localparam logic [ADDRBITS:0]   TAPS_X   = (ADDRBITS + 1)'(FILTER_TAPS);

  typedef enum logic [1:0] {IDLE, CLEAR, MAC, OUT} state_t;

  state_t              state, state_nxt;
  logic [ADDRBITS-1:0] wr_ptr, wr_ptr_nxt;
  logic [ADDRBITS-1:0] newest, newest_nxt;
  logic [ADDRBITS-1:0] tap_cnt, tap_cnt_nxt;
  logic [ADDRBITS-1:0] tap_inc;
  logic [ADDRBITS-1:0] coeff_addr_nxt, data_addr_nxt;
  logic [1:0]          acc_cmd_nxt;
  logic                sample_we_nxt, out_valid_nxt;

  // Read address (newest - tap) mod FILTER_TAPS; one extra bit keeps non-power-of-2 depths in range.
  function automatic logic [ADDRBITS-1:0] rd_addr(input logic [ADDRBITS-1:0] base,
                                                  input logic [ADDRBITS-1:0] tap);
    logic [ADDRBITS:0] sum;
    sum = {1'b0, base} + TAPS_X - {1'b0, tap};
    if (sum >= TAPS_X) sum = sum - TAPS_X;
    return sum[ADDRBITS-1:0];
  endfunction

  function automatic logic [ADDRBITS-1:0] ptr_inc(input logic [ADDRBITS-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign in_ready = (state == IDLE);
  assign tap_inc  = tap_cnt + 1'b1;

  // Outputs are registered from the next state, so each cycle's outputs belong to the state of that cycle.
  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    newest_nxt     = newest;
    tap_cnt_nxt    = tap_cnt;
    coeff_addr_nxt = coeff_addr;
    data_addr_nxt  = data_addr;
    acc_cmd_nxt    = ACC_NOP;
    sample_we_nxt  = 1'b0;
    out_valid_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt     = CLEAR;
          sample_we_nxt = 1'b1;
          data_addr_nxt = wr_ptr;
          newest_nxt    = wr_ptr;
          wr_ptr_nxt    = ptr_inc(wr_ptr);
          tap_cnt_nxt   = '0;
          acc_cmd_nxt   = ACC_CLEAR;
        end
      end
      CLEAR: begin
        state_nxt      = MAC;
        tap_cnt_nxt    = '0;
        acc_cmd_nxt    = ACC_LOAD;
        coeff_addr_nxt = '0;
        data_addr_nxt  = newest;
      end
      MAC: begin
        if (tap_cnt == LAST_IDX) begin
          state_nxt     = OUT;
          out_valid_nxt = 1'b1;
        end else begin
          tap_cnt_nxt    = tap_inc;
          acc_cmd_nxt    = ACC_LOAD;
          coeff_addr_nxt = tap_inc;
          data_addr_nxt  = rd_addr(newest, tap_inc);
        end
      end
      OUT: begin
        if (out_ready) state_nxt = IDLE;
        else           out_valid_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      newest     <= '0;
      tap_cnt    <= '0;
      coeff_addr <= '0;
      data_addr  <= '0;
      acc_cmd    <= ACC_NOP;
      sample_we  <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      newest     <= newest_nxt;
      tap_cnt    <= tap_cnt_nxt;
      coeff_addr <= coeff_addr_nxt;
      data_addr  <= data_addr_nxt;
      acc_cmd    <= acc_cmd_nxt;
      sample_we  <= sample_we_nxt;
      out_valid  <= out_valid_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

`ifdef FILTER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          sample_cnt <= '0;
    else if (state == OUT && out_ready)  sample_cnt <= sample_cnt + 16'd1;
  end
`endif

  a_load_only_in_mac: assert property (@(posedge clk) disable iff (!rst_n)
    (acc_cmd == ACC_LOAD) |-> (state == MAC));
  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(acc_cmd)));
  a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n)
    in_ready == (state == IDLE));

endmodule

// File: tb/tb_filter_ctrl.sv
// Bench for filter_ctrl (FILTER_TAPS=4): behavioural RAM/ROM/accumulator around the controller,
// expected FIR results computed as a plain tap sum over a model of the sample history.
module tb_filter_ctrl;

  localparam int N  = 4;
  localparam int AB = 2;
  localparam logic [1:0] ACC_NOP   = 2'b00;
  localparam logic [1:0] ACC_CLEAR = 2'b01;
  localparam logic [1:0] ACC_LOAD  = 2'b10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, sample_we, out_valid, busy;
  logic [AB-1:0] coeff_addr, data_addr;
  logic [1:0]    acc_cmd;
`ifdef FILTER_CNT_EN
  logic [15:0]   sample_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  filter_ctrl #(.FILTER_TAPS(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sample_we(sample_we), .coeff_addr(coeff_addr), .data_addr(data_addr),
    .acc_cmd(acc_cmd), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
`ifdef FILTER_CNT_EN
    , .sample_cnt(sample_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Datapath stand-in: sample RAM, coefficient ROM and accumulator driven by the controller.
  logic [7:0]  ram [N];
  logic [7:0]  coef [N];
  logic [31:0] acc;
  logic [7:0]  cur_sample = 8'd0;
  logic        ram_init = 1'b0;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < N; i++) ram[i] <= 8'd0;
    end else if (sample_we) begin
      ram[data_addr] <= cur_sample;
    end
    case (acc_cmd)
      ACC_CLEAR: acc <= 32'd0;
      ACC_LOAD:  acc <= acc + coef[coeff_addr] * ram[data_addr];
      default:   ;
    endcase
  end

  // Reference model: sample history ring, write position, handshake count.
  logic [7:0] mram [N];
  int         mptr = 0;
  int         n_hs = 0;
  int         last_result = 0;

  function automatic int model_out(input int newest);
    int sum = 0;
    for (int k = 0; k < N; k++)
      sum += int'(coef[k]) * int'(mram[(newest - k + N) % N]);
    return sum;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_check(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("idle_acc_cmd", acc_cmd, ACC_NOP);
      check("idle_out_valid", out_valid, 1'b0);
      check("idle_in_ready", in_ready, 1'b1);
      check("idle_busy", busy, 1'b0);
    end
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_acc_cmd", acc_cmd, ACC_NOP);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sample_we", sample_we, 1'b0);
    check("rst_coeff_addr", coeff_addr, 0);
    check("rst_data_addr", data_addr, 0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
`ifdef FILTER_CNT_EN
    check("rst_sample_cnt", sample_cnt, 0);
    n_hs = 0;
`endif
    mptr  = 0;
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] v, input int hold);
    int newest;
    int expv;
    @(negedge clk);
    cur_sample = v;
    in_valid   = 1'b1;
    check("in_ready_before", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    newest = mptr;
    mram[newest] = v;
    mptr = (mptr + 1) % N;
    check("clear_cmd", acc_cmd, ACC_CLEAR);
    check("clear_we", sample_we, 1'b1);
    check("clear_waddr", data_addr, newest);
    check("clear_in_ready", in_ready, 1'b0);
    check("clear_busy", busy, 1'b1);
    for (int t = 0; t < N; t++) begin
      @(negedge clk);
      check("mac_cmd", acc_cmd, ACC_LOAD);
      check("mac_coeff_addr", coeff_addr, t);
      check("mac_data_addr", data_addr, (newest - t + N) % N);
      check("mac_we", sample_we, 1'b0);
      check("mac_out_valid", out_valid, 1'b0);
    end
    expv = model_out(newest);
    @(negedge clk);
    check("out_valid", out_valid, 1'b1);
    check("out_cmd", acc_cmd, ACC_NOP);
    check("out_result", acc, expv);
    last_result = expv;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_result", acc, expv);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_cmd", acc_cmd, ACC_NOP);
      check("hold_we", sample_we, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_hs++;
    check("post_out_valid", out_valid, 1'b0);
    check("post_in_ready", in_ready, 1'b1);
    check("post_busy", busy, 1'b0);
`ifdef FILTER_CNT_EN
    check("sample_cnt", sample_cnt, n_hs % 65536);
`endif
  endtask

  int exp_dir [5] = '{1, 3, 6, 10, 14};

  initial begin
    for (int i = 0; i < N; i++) begin
      coef[i] = 8'd1;
      mram[i] = 8'd0;
    end
    @(negedge clk);
    ram_init = 1'b1;
    @(negedge clk);
    ram_init = 1'b0;

    do_reset();
    idle_check(10);

    // Ramp 1..5 with unit coefficients; the fifth write wraps to address 0.
    for (int i = 0; i < 5; i++) begin
      send(8'(i + 1), 0);
      check("ramp_result", last_result, exp_dir[i]);
    end

    // Downstream stalls for 7 cycles; a pending input must stay unaccepted.
    send(8'd9, 7);
    idle_check(2);

    // Asynchronous reset in the second MAC cycle discards the result.
    @(negedge clk);
    cur_sample = 8'd7;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    mram[mptr] = 8'd7;
    @(negedge clk);
    @(negedge clk);
    check("midmac_cmd_before", acc_cmd, ACC_LOAD);
    rst_n = 1'b0;
    #1;
    check("midmac_rst_cmd", acc_cmd, ACC_NOP);
    check("midmac_rst_out_valid", out_valid, 1'b0);
    check("midmac_rst_in_ready", in_ready, 1'b1);
    check("midmac_rst_busy", busy, 1'b0);
    mptr = 0;
`ifdef FILTER_CNT_EN
    n_hs = 0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    send(8'd3, 0);

    // Randomized samples, coefficients, idle gaps and downstream stalls.
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0)
        for (int k = 0; k < N; k++) coef[k] = 8'($urandom_range(0, 255));
      idle_check($urandom_range(0, 3));
      send(8'($urandom_range(0, 255)), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
